// File: rtl/clk_freq_lock_det.sv
// clk_freq_lock_det: frequency lock detector for a divided monitored clock.
// Counts mon_toggle transitions per WINDOW_CYCLES window of clk_ref, range
// checks the count and drives a hysteresis lock FSM.
// Optional stall detector enabled by defining CLKMON_STUCK_DET_EN.
module clk_freq_lock_det #(
  parameter int WINDOW_CYCLES  = 1024,
  parameter int CNT_W          = 16,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic             clk_ref,
  input  logic             reset,
  input  logic             mon_toggle,
  input  logic [CNT_W-1:0] cnt_min,
  input  logic [CNT_W-1:0] cnt_max,
  output logic             locked,
  output logic [CNT_W-1:0] freq_count,
  output logic             meas_valid,
  output logic             stuck
);

  localparam int WW      = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int RUN_MAX = (LOCK_WINDOWS > UNLOCK_WINDOWS) ? LOCK_WINDOWS : UNLOCK_WINDOWS;
  localparam int RW      = $clog2(RUN_MAX + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  localparam logic [RW-1:0] LOCK_N   = RW'(LOCK_WINDOWS);
  localparam logic [RW-1:0] UNLOCK_N = RW'(UNLOCK_WINDOWS);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2,
    S_HOLDOVER = 2'd3
  } state_e;

  logic             sync1_q, sync2_q, sync3_q;
  logic             trans;
  logic [WW-1:0]    win_q;
  logic             win_end;
  logic [CNT_W-1:0] tcnt_q, tcnt_inc;
  logic [CNT_W-1:0] freq_q;
  logic             mv_q;
  logic             good;
  state_e           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic             locked_q, locked_d;
  logic             stuck_q;

  // Two-flop synchroniser plus an edge-detect flop on the async toggle
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= mon_toggle;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign trans    = sync2_q ^ sync3_q;
  assign win_end  = (win_q == WIN_LAST);
  // Saturating increment; the window-end capture uses this so a transition
  // seen on the last cycle still lands in the reported count.
  assign tcnt_inc = (trans && (tcnt_q != {CNT_W{1'b1}})) ? tcnt_q + 1'b1 : tcnt_q;
  assign good     = (cnt_min <= tcnt_inc) && (tcnt_inc <= cnt_max);

  // Gate window, transition counter and count capture
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      tcnt_q <= '0;
      freq_q <= '0;
      mv_q   <= 1'b0;
    end else begin
      mv_q <= win_end;
      if (win_end) begin
        win_q  <= '0;
        tcnt_q <= '0;
        freq_q <= tcnt_inc;
      end else begin
        win_q  <= win_q + 1'b1;
        tcnt_q <= tcnt_inc;
      end
    end
  end

`ifdef CLKMON_STUCK_DET_EN
  localparam int STALL_LIM = WINDOW_CYCLES / 4;
  localparam int SW        = $clog2(STALL_LIM + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIM);

  logic [SW-1:0] stall_q, stall_d;
  logic          stuck_d;

  // Stall counter restarts on every transition and saturates at the limit
  always_comb begin
    stall_d = stall_q;
    stuck_d = stuck_q;
    if (trans) begin
      stall_d = '0;
      stuck_d = 1'b0;
    end else begin
      if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
      if (stall_d == STALL_MAX) stuck_d = 1'b1;
    end
  end

  // Stall state registers
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      stuck_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      stuck_q <= stuck_d;
    end
  end
`else
  assign stuck_q = 1'b0;
`endif

  // Lock FSM next state: only window end moves it, except a stall override
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (win_end) begin
      unique case (state_q)
        S_UNLOCKED: if (good) begin
          if (LOCK_WINDOWS == 1) state_d = S_LOCKED;
          else begin
            state_d = S_ACQUIRE;
            run_d   = RUN_ONE;
          end
        end
        S_ACQUIRE: begin
          if (!good) begin
            state_d = S_UNLOCKED;
            run_d   = '0;
          end else if (run_q + RUN_ONE == LOCK_N) begin
            state_d = S_LOCKED;
            run_d   = '0;
          end else run_d = run_q + RUN_ONE;
        end
        S_LOCKED: if (!good) begin
          if (UNLOCK_WINDOWS == 1) state_d = S_UNLOCKED;
          else begin
            state_d = S_HOLDOVER;
            run_d   = RUN_ONE;
          end
        end
        S_HOLDOVER: begin
          if (good) begin
            state_d = S_LOCKED;
            run_d   = '0;
          end else if (run_q + RUN_ONE == UNLOCK_N) begin
            state_d = S_UNLOCKED;
            run_d   = '0;
          end else run_d = run_q + RUN_ONE;
        end
      endcase
    end
    if (stuck_q) begin
      state_d = S_UNLOCKED;
      run_d   = '0;
    end
    locked_d = (state_d == S_LOCKED) || (state_d == S_HOLDOVER);
  end

  // FSM state and registered lock output
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state_q  <= S_UNLOCKED;
      run_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      locked_q <= locked_d;
    end
  end

  assign locked     = locked_q;
  assign freq_count = freq_q;
  assign meas_valid = mv_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_freq_lock_det.sv
// Directed bench for clk_freq_lock_det: lock/holdover/acquire sequencing,
// count saturation (8-bit instance), inverted range, stall and async reset.
module tb_clk_freq_lock_det;
  logic        clk_ref = 1'b0;
  logic        reset   = 1'b1;
  logic        mon     = 1'b0;
  logic        mon1    = 1'b0;
  logic [15:0] cnt_min = 16'd250;
  logic [15:0] cnt_max = 16'd262;
  logic        locked, meas_valid, stuck;
  logic [15:0] freq_count;
  logic        locked1, meas_valid1, stuck1;
  logic [7:0]  freq_count1;
  int          per = 0;
  int          ph  = 0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk_ref = ~clk_ref;

  clk_freq_lock_det u0 (
    .clk_ref(clk_ref), .reset(reset), .mon_toggle(mon),
    .cnt_min(cnt_min), .cnt_max(cnt_max),
    .locked(locked), .freq_count(freq_count),
    .meas_valid(meas_valid), .stuck(stuck)
  );

  clk_freq_lock_det #(.CNT_W(8)) u1 (
    .clk_ref(clk_ref), .reset(reset), .mon_toggle(mon1),
    .cnt_min(8'd200), .cnt_max(8'd255),
    .locked(locked1), .freq_count(freq_count1),
    .meas_valid(meas_valid1), .stuck(stuck1)
  );

  // Toggle generators driven away from the active edge
  initial forever begin
    @(negedge clk_ref);
    mon1 = ~mon1;
    if (per != 0) begin
      if (ph >= per - 1) begin
        ph  = 0;
        mon = ~mon;
      end else ph++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Wait for the next meas_valid pulse, bounded by a bit over one window
  task automatic wait_mv();
    int n;
    n = 0;
    while (n < 1100) begin
      @(posedge clk_ref); #1;
      if (meas_valid) break;
      n++;
    end
    if (n >= 1100) chk("mv_timeout", 0, 1);
  endtask

  // One window: check locked level and whether the count is in [lo,hi]
  task automatic win(input string tag, input logic exp_lk, input int lo, input int hi);
    wait_mv();
    chk({tag, "_lk"}, locked, exp_lk);
    chk({tag, "_cnt"}, (freq_count >= lo && freq_count <= hi), 1);
  endtask

  initial begin
    int n;
    per = 4;
    repeat (5) @(posedge clk_ref);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_freq", freq_count, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_stuck", stuck, 0);
    @(negedge clk_ref); reset = 1'b0;

    // Acquire: 256 transitions per window, lock on window 4
    win("acq1", 0, 255, 257);
    chk("u1_sat", freq_count1, 255);
    chk("u1_mv", meas_valid1, 1);
    @(posedge clk_ref); #1;
    chk("mv_pulse", meas_valid, 0);
    win("acq2", 0, 255, 257);
    win("acq3", 0, 255, 257);
    win("acq4", 1, 255, 257);
    chk("u1_lock", locked1, 1);
    chk("u1_sat2", freq_count1, 255);

    // Half rate: holdover after one bad window, unlock after the second
    per = 8;
    win("slow1", 1, 127, 129);
    win("slow2", 0, 127, 129);

    // Relock needs four fresh good windows
    per = 4;
    win("rl1", 0, 250, 262);
    win("rl2", 0, 250, 262);
    win("rl3", 0, 250, 262);
    win("rl4", 1, 250, 262);

    // One bad window then good windows: never drops
    per = 8;
    win("hb1", 1, 120, 136);
    per = 4;
    win("hg1", 1, 250, 262);
    win("hg2", 1, 250, 262);

    // Unlock, then ACQUIRE interrupted at run=3
    per = 8;
    win("ul1", 1, 120, 136);
    win("ul2", 0, 120, 136);
    per = 4;
    win("aq1", 0, 250, 262);
    win("aq2", 0, 250, 262);
    win("aq3", 0, 250, 262);
    per = 8;
    win("aqbad", 0, 120, 136);
    per = 4;
    win("fr1", 0, 250, 262);
    win("fr2", 0, 250, 262);
    win("fr3", 0, 250, 262);
    win("fr4", 1, 250, 262);

    // Inverted range: every window bad
    cnt_min = 16'd300;
    cnt_max = 16'd200;
    win("inv1", 1, 255, 257);
    win("inv2", 0, 255, 257);
    win("inv3", 0, 255, 257);
    win("inv4", 0, 255, 257);
    win("inv5", 0, 255, 257);
    win("inv6", 0, 255, 257);

    // Restore range and lock again before the stall test
    cnt_min = 16'd250;
    cnt_max = 16'd262;
    win("sl1", 0, 255, 257);
    win("sl2", 0, 255, 257);
    win("sl3", 0, 255, 257);
    win("sl4", 1, 255, 257);
    per = 0;
`ifdef CLKMON_STUCK_DET_EN
    n = 0;
    while (n < 400 && locked) begin
      @(posedge clk_ref); #1;
      n++;
    end
    chk("stall_stuck", stuck, 1);
    chk("stall_lk", locked, 0);
    chk("stall_time", (n >= 250 && n <= 270), 1);
`else
    n = 0;
    repeat (300) begin
      @(posedge clk_ref); #1;
      if (stuck) n++;
    end
    chk("nostall_stuck", n, 0);
    chk("nostall_lk", locked, 1);
`endif

    // Mid-window async reset clears every output at once
    repeat (100) @(posedge clk_ref);
    @(negedge clk_ref);
    reset = 1'b1;
    #1;
    chk("mrst_locked", locked, 0);
    chk("mrst_freq", freq_count, 0);
    chk("mrst_mv", meas_valid, 0);
    chk("mrst_stuck", stuck, 0);
    chk("mrst_u1_lk", locked1, 0);
    chk("mrst_u1_freq", freq_count1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_freq_lock_det.md
Name: clk_freq_lock_det

Overview:
- Upstream stage of the clock-monitor unlock counter. It produces the `locked` level that the unlock counter synchronises, then counts falling edges of.
- Measures a divided-down monitored clock against `clk_ref` by counting toggle transitions over a fixed gate window.
- Compares each window count against a programmable range.
- Runs a hysteresis FSM that asserts or deasserts `locked`.
- Also exports the last measured count for register readback.

Parameters:
- WINDOW_CYCLES, 1024: `clk_ref` cycles per measurement window; must be >= 8.
- CNT_W, 16: width of the transition counter, `freq_count`, `cnt_min` and `cnt_max`.
- LOCK_WINDOWS, 4: consecutive in-range windows needed to assert `locked`; must be >= 1.
- UNLOCK_WINDOWS, 2: consecutive out-of-range windows needed to drop `locked`; must be >= 1.

Ports:
- clk_ref  in  1  reference clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- mon_toggle  in  1  asynchronous toggle; flips once per divided monitored-clock period.
- cnt_min  in  CNT_W  lower bound of the good range, inclusive; quasi-static.
- cnt_max  in  CNT_W  upper bound of the good range, inclusive; quasi-static.
- locked  out  1  registered lock indication.
- freq_count  out  CNT_W  transition count of the last completed window.
- meas_valid  out  1  one-cycle pulse when `freq_count` updates.
- stuck  out  1  toggle-stall flag; see Optional Feature.

Behaviour:
- Reset: `locked`=0, `freq_count`=0, `meas_valid`=0, `stuck`=0. FSM goes to UNLOCKED; window and transition counters go to 0. Reset is honoured mid-window and discards the partial count.
- Input path:
  - `mon_toggle` passes through a 2-FF synchroniser, then a third flop for edge detection.
  - A transition is sync2 != sync3. Both rising and falling transitions count.
  - Latency from an input change to the counted transition is 3 cycles.
- Window counter:
  - Runs 0..WINDOW_CYCLES-1 and wraps.
  - On the last cycle: `freq_count` <= transition count, including any transition detected that same cycle. The transition counter clears to 0. `meas_valid` pulses on the next cycle, aligned with the new `freq_count`.
- Transition counter saturates at all-ones and does not wrap.
- Range check: good = (cnt_min <= count <= cnt_max), evaluated on the window-end count. Thresholds are sampled only at window end. If cnt_min > cnt_max, every window is bad.
- FSM: states advance only on window end; there is no change between windows.
  - UNLOCKED (locked=0):
    - good & LOCK_WINDOWS==1 -> LOCKED.
    - good -> ACQUIRE with run=1.
    - bad -> stay.
  - ACQUIRE (locked=0):
    - bad -> UNLOCKED, run=0.
    - good & run+1==LOCK_WINDOWS -> LOCKED.
    - otherwise run++.
  - LOCKED (locked=1):
    - good -> stay.
    - bad & UNLOCK_WINDOWS==1 -> UNLOCKED.
    - bad -> HOLDOVER with run=1.
  - HOLDOVER (locked=1):
    - good -> LOCKED, run=0.
    - bad & run+1==UNLOCK_WINDOWS -> UNLOCKED.
    - otherwise run++.
- `locked` is registered and changes on the same edge that `meas_valid` rises; it is glitch-free for the downstream synchroniser.
- Run counter width is clog2(max(LOCK_WINDOWS,UNLOCK_WINDOWS)+1).

Optional Feature:
- Macro: CLKMON_STUCK_DET_EN.
- Defined:
  - A stall counter clears on every detected transition and increments otherwise, saturating.
  - When it reaches WINDOW_CYCLES/4, `stuck` is set and the FSM is forced to UNLOCKED on the next cycle (`locked`=0, run=0), without waiting for window end.
  - `stuck` clears on the next detected transition.
  - Window counting and `freq_count` are unaffected.
- Not defined: `stuck` is tied to 0 and there is no stall logic.

Test Plan:
- Reset, then toggle every 4 clk_ref cycles with cnt_min=250, cnt_max=262, WINDOW_CYCLES=1024 -> `freq_count` in 255..257 on each `meas_valid`; `locked` rises at window end 4; no earlier rise.
- Locked, then toggle every 8 cycles (~128 per window) -> `locked` stays 1 after the first bad window (HOLDOVER) and falls at the second bad window end.
- Locked, then one bad window then a good window -> `locked` never drops; a third window keeps LOCKED.
- ACQUIRE at run=3 when a bad window arrives -> back to UNLOCKED; a fresh 4 good windows are needed to lock.
- Toggle every cycle with CNT_W=8, WINDOW_CYCLES=1024 -> `freq_count`=255 (saturated); cnt_min=300 vs cnt_max=200 -> never locks.
- CLKMON_STUCK_DET_EN, locked, `mon_toggle` held static -> `stuck`=1 and `locked`=0 about 256+3 cycles after the last transition; `reset` asserted mid-window -> all outputs 0 immediately.
